// File: rtl/dmem_access_unit_pkg.sv
// Shared types for the data-memory access path: request sizes, FSM states, latched request.
// Pure type/constant package; no timing or flow control of its own.
package mips_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              uns;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic              err;
    } req_t;

endpackage

// File: rtl/mem_lane_unit.sv
// Little-endian lane merge for sub-word stores and lane extract/extend for loads.
// Purely combinational, zero latency; no flow control.
module mem_lane_unit
    import mips_mem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        byte_off,
    input  logic              is_unsigned,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] rdbuf,
    output logic [WORD_W-1:0] merged,
    output logic [WORD_W-1:0] extracted
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_sh   = {byte_off, 3'b000};
        half_sh   = {byte_off[1], 4'b0000};
        byte_v    = 8'(rdbuf >> byte_sh);
        half_v    = 16'(rdbuf >> half_sh);
        merged    = wdata;
        extracted = rdbuf;
        case (size)
            SZ_BYTE: begin
                merged    = (rdbuf & ~(32'h0000_00FF << byte_sh))
                          | ({24'h0, wdata[7:0]} << byte_sh);
                extracted = {{24{~is_unsigned & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                merged    = (rdbuf & ~(32'h0000_FFFF << half_sh))
                          | ({16'h0, wdata[15:0]} << half_sh);
                extracted = {{16{~is_unsigned & half_v[15]}}, half_v};
            end
            default: begin
                merged    = wdata;
                extracted = rdbuf;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Pipeline-side initiator for a word-wide dmem; sub-word stores are read-modify-write.
// Latency: error 1, load 2, word store 2, sub-word store 3; req_ready only in IDLE, one request in flight.
module dmem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [WORD_W-1:0] resp_rdata,
    output logic [WORD_W-1:0] mem_a,
    output logic [WORD_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [WORD_W-1:0] mem_rd
);

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [WORD_W-1:0] rdbuf_q, rdbuf_d;

    logic              req_err;
    logic [WORD_W-1:0] merged;
    logic [WORD_W-1:0] extracted;

    mem_lane_unit u_lane (
        .size        (req_q.size),
        .byte_off    (req_q.addr[1:0]),
        .is_unsigned (req_q.uns),
        .wdata       (req_q.wdata),
        .rdbuf       (rdbuf_q),
        .merged      (merged),
        .extracted   (extracted)
    );

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
        if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS)) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdbuf_d = rdbuf_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = '{we:    req_we,
                              size:  req_size,
                              uns:   req_unsigned,
                              addr:  req_addr,
                              wdata: req_wdata,
                              err:   req_err};
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                rdbuf_d = mem_rd;
                state_d = req_q.we ? WRITE : RESP;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // mem_we is gated by reset_n so a reset landing in WRITE never commits.
    always_comb begin
        req_ready  = (state_q == IDLE);
        mem_a      = (state_q != IDLE) ? {req_q.addr[31:2], 2'b00} : '0;
        mem_we     = (state_q == WRITE) & reset_n;
        mem_wd     = (state_q == WRITE) ? merged : '0;
        resp_valid = (state_q == RESP);
        resp_err   = (state_q == RESP) & req_q.err;
        resp_rdata = ((state_q == RESP) && !req_q.we && !req_q.err) ? extracted : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdbuf_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdbuf_q <= rdbuf_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed vector table, reset/handshake sequences, random vs byte-array model.
module tb_dmem_access_unit;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [64];
    logic        pre_en;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;
    logic [7:0]  ref_b [256];

    dmem_access_unit #(.MEM_WORDS(64)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_we       (mem_we),
        .mem_rd       (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = (mem_a[31:2] < 30'd64) ? mem[mem_a[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (mem_we && (mem_a[31:2] < 30'd64)) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          wecnt;
        logic [31:0] wd_exp;
        logic [31:0] wa_exp;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = 6'(idx);
        pre_val = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
        for (int b = 0; b < 4; b++) ref_b[idx*4 + b] = val[8*b +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    // Byte-addressed reference: memory is a plain byte array, accesses are n consecutive bytes.
    task automatic ref_access(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic err, output logic [31:0] rd, output int lat);
        int n;
        int base;
        logic [31:0] v;
        err = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) ||
              (sz == 2'd2 && addr % 4 != 0) || (addr / 4 >= 64);
        rd = 32'h0;
        n = 1 << sz;
        if (err) begin
            lat = 1;
        end else begin
            base = int'(addr[7:0]);
            if (!we) begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_b[base+i]) << (8*i));
                if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                rd  = v;
                lat = 2;
            end else begin
                for (int i = 0; i < n; i++) ref_b[base+i] = wd[8*i +: 8];
                lat = (n == 4) ? 2 : 3;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic err, output logic [31:0] rd, output int lat,
                          output int wecnt, output logic [31:0] last_wd, output logic [31:0] last_wa);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99; wecnt = 0; err = 1'b0; rd = 32'h0; last_wd = 32'h0; last_wa = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_we) begin
                wecnt++;
                last_wd = mem_wd;
                last_wa = mem_a;
            end
            if (resp_valid) begin
                lat = c;
                err = resp_err;
                rd  = resp_rdata;
                break;
            end
        end
    endtask

    initial begin
        logic        g_err, e_err;
        logic [31:0] g_rd, e_rd, g_wd, g_wa;
        int          g_lat, e_lat, g_wec;
        logic [6:0]  rdy_mask, rsp_mask;
        logic [31:0] hs_rd0, hs_rd1;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr, wd;
        int          r;

        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        pre_en = 1'b0; pre_idx = 6'd0; pre_val = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        reset_n = 1'b1;

        for (int w = 0; w < 64; w++) preload(w, $urandom);
        preload(0, 32'h0000_0000);
        preload(2, 32'h80FF_7F01);
        preload(4, 32'h1122_3344);
        preload(8, 32'h0102_0304);
        preload(63, 32'h5A5A_A5A5);

        tv.push_back('{1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF, 1'b0, 32'h0, 3, 1, 32'hBEEF_3344, 32'h10});
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hBEEF_3344, 2, 0, 32'h0, 32'h0});
        tv.push_back('{1'b0, 2'd0, 1'b0, 32'h09, 32'h0, 1'b0, 32'h0000_007F, 2, 0, 32'h0, 32'h0});
        tv.push_back('{1'b0, 2'd0, 1'b0, 32'h0A, 32'h0, 1'b0, 32'hFFFF_FFFF, 2, 0, 32'h0, 32'h0});
        tv.push_back('{1'b0, 2'd0, 1'b1, 32'h0B, 32'h0, 1'b0, 32'h0000_0080, 2, 0, 32'h0, 32'h0});
        tv.push_back('{1'b0, 2'd1, 1'b0, 32'h0A, 32'h0, 1'b0, 32'hFFFF_80FF, 2, 0, 32'h0, 32'h0});
        tv.push_back('{1'b0, 2'd1, 1'b1, 32'h0A, 32'h0, 1'b0, 32'h0000_80FF, 2, 0, 32'h0, 32'h0});
        tv.push_back('{1'b1, 2'd2, 1'b0, 32'h00, 32'hCAFE_F00D, 1'b0, 32'h0, 2, 1, 32'hCAFE_F00D, 32'h0});
        tv.push_back('{1'b1, 2'd0, 1'b0, 32'h01, 32'h1234_5699, 1'b0, 32'h0, 3, 1, 32'hCAFE_990D, 32'h0});
        tv.push_back('{1'b0, 2'd1, 1'b0, 32'h02, 32'h0, 1'b0, 32'hFFFF_CAFE, 2, 0, 32'h0, 32'h0});
        tv.push_back('{1'b0, 2'd1, 1'b0, 32'h03, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0});
        tv.push_back('{1'b1, 2'd2, 1'b0, 32'h06, 32'hDEAD_BEEF, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0});
        tv.push_back('{1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0});
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0});
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, 1'b0, 32'h5A5A_A5A5, 2, 0, 32'h0, 32'h0});
        tv.push_back('{1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0});
        tv.push_back('{1'b1, 2'd0, 1'b0, 32'h100, 32'h55, 1'b1, 32'h0, 1, 0, 32'h0, 32'h0});

        foreach (tv[i]) begin
            do_req(tv[i].we, tv[i].sz, tv[i].uns, tv[i].addr, tv[i].wd, g_err, g_rd, g_lat, g_wec, g_wd, g_wa);
            ref_access(tv[i].we, tv[i].sz, tv[i].uns, tv[i].addr, tv[i].wd, e_err, e_rd, e_lat);
            check($sformatf("vec%0d_err", i), 32'(g_err), 32'(tv[i].err));
            check($sformatf("vec%0d_rdata", i), g_rd, tv[i].rdata);
            check($sformatf("vec%0d_lat", i), 32'(g_lat), 32'(tv[i].lat));
            check($sformatf("vec%0d_wecnt", i), 32'(g_wec), 32'(tv[i].wecnt));
            if (tv[i].wecnt > 0) begin
                check($sformatf("vec%0d_mem_wd", i), g_wd, tv[i].wd_exp);
                check($sformatf("vec%0d_mem_a", i), g_wa, tv[i].wa_exp);
            end
        end

        // Reset asserted while a byte store sits in WRITE.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'hAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("rst_in_write_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_after_ready", 32'(req_ready), 32'd1);
        check("rst_after_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_after_mem8", mem[8], 32'h0102_0304);

        // req_valid held across a load: second acceptance only after RESP.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        rdy_mask = '0; rsp_mask = '0; hs_rd0 = '0; hs_rd1 = '0;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            rdy_mask[k] = req_ready;
            rsp_mask[k] = resp_valid;
            if (k == 2) hs_rd0 = resp_rdata;
            if (k == 5) begin
                hs_rd1 = resp_rdata;
                req_valid = 1'b0;
            end
        end
        check("hs_ready_mask", 32'(rdy_mask), 32'b1001001);
        check("hs_resp_mask", 32'(rsp_mask), 32'b0100100);
        check("hs_rdata0", hs_rd0, 32'hBEEF_3344);
        check("hs_rdata1", hs_rd1, 32'hBEEF_3344);

        for (int it = 0; it < 300; it++) begin
            r   = $urandom_range(0, 9);
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            wd  = $urandom;
            if (r < 8)       addr = 32'($urandom_range(0, 255));
            else if (r == 8) addr = 32'(256 + $urandom_range(0, 15));
            else             addr = $urandom;
            if (r < 6) begin
                if (sz == 2'd1) addr[0] = 1'b0;
                if (sz == 2'd2) addr[1:0] = 2'b00;
            end
            do_req(we, sz, uns, addr, wd, g_err, g_rd, g_lat, g_wec, g_wd, g_wa);
            ref_access(we, sz, uns, addr, wd, e_err, e_rd, e_lat);
            check($sformatf("rnd%0d_err", it), 32'(g_err), 32'(e_err));
            check($sformatf("rnd%0d_rdata", it), g_rd, e_rd);
            check($sformatf("rnd%0d_lat", it), 32'(g_lat), 32'(e_lat));
            check($sformatf("rnd%0d_wecnt", it), 32'(g_wec), (!e_err && we) ? 32'd1 : 32'd0);
        end

        @(negedge clk);
        for (int w = 0; w < 64; w++) check($sformatf("final_mem%0d", w), mem[w], ref_word(w));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Processor-side initiator for the word-wide data memory (`dmem`: combinational read, write on posedge, one word-write enable).
- Accepts byte/halfword/word load and store requests from the MIPS pipeline through a valid/ready handshake.
- Issues word-aligned accesses to `dmem`, doing read-modify-write for sub-word stores.
- Returns extracted, sign- or zero-extended load data, or an error response.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the attached data memory; word index >= MEM_WORDS is out of range.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset_n  input  1  synchronous, active-low reset.
- req_valid  input  1  pipeline presents a request.
- req_ready  output  1  unit can accept; a transfer occurs when req_valid & req_ready at posedge.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: zero-extend (lbu/lhu) instead of sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the sub-word value is in the low bits.
- resp_valid  output  1  one-cycle pulse: request complete.
- resp_err  output  1  qualifies resp_valid: misaligned, illegal size or out of range; no memory write occurred.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- mem_a  output  32  word-aligned address to dmem ({addr[31:2],2'b00}).
- mem_wd  output  32  write data to dmem.
- mem_we  output  1  write enable to dmem.
- mem_rd  input  32  read data from dmem (combinational from mem_a).

Behaviour:
- Reset (reset_n low at posedge):
  - state goes to IDLE and all latches clear to 0.
  - mem_we is combinationally gated by reset_n, so no write commits during a reset cycle, including reset asserted in WRITE.
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_a=0, mem_wd=0, mem_we=0.
- Byte lanes are little-endian: byte k (addr[1:0]=k) is bits [8k+7:8k]; halfword addr[1]=h is bits [16h+15:16h].
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On transfer, latch all request fields, then:
  - error (size 11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= MEM_WORDS) -> RESP with error flag set.
  - word store -> WRITE.
  - load or sub-word store -> READ.
- READ: mem_a=latched word address, mem_we=0; capture mem_rd into rdbuf at posedge. Load -> RESP; sub-word store -> WRITE.
- WRITE: mem_we=1.
  - mem_wd = req_wdata for word stores.
  - For sub-word stores, mem_wd = rdbuf with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
  - Then -> RESP.
- RESP: resp_valid=1 for exactly one cycle. resp_err = latched error flag. resp_rdata = extracted value for loads, else 0. Then -> IDLE.
- req_ready=0 in READ, WRITE and RESP; requests presented then are ignored and must be held by the pipeline. No back-to-back acceptance in RESP.
- Latency (transfer at cycle 0, resp_valid in cycle N):
  - load N=2.
  - word store N=2.
  - sub-word store N=3.
  - error N=1.
- Timing of outputs:
  - mem_we is high only in WRITE.
  - mem_a holds the latched word address in all non-IDLE states.
  - mem_wd is 0 outside WRITE.
- Extension:
  - byte: bit 7 replicated unless req_unsigned.
  - half: bit 15 replicated unless req_unsigned.
  - word: unchanged; req_unsigned ignored.
- Boundary: the word at index MEM_WORDS-1 is legal. Address 0xFFFFFFFC is out of range when MEM_WORDS=64.

Decomposition:
- Package mips_mem_pkg: size enum (SZ_BYTE, SZ_HALF, SZ_WORD), state enum (IDLE, READ, WRITE, RESP), word-width constant.
- One combinational sub-module, mem_lane_unit: lane merge for stores and lane extract/extend for loads. The FSM and latches stay in dmem_access_unit.

Test Plan:
- Word RMW pair: mem[4]=0x11223344; store size 01, addr 0x12, data 0xBEEF -> READ, then WRITE with mem_wd=0xBEEF3344; resp_valid at cycle 3; load word 0x10 returns 0xBEEF3344.
- Loads of mem[2]=0x80FF7F01:
  - lb 0x09 -> 0x0000007F.
  - lb 0x0A -> 0xFFFFFFFF.
  - lbu 0x0B -> 0x00000080.
  - lh 0x0A -> 0xFFFF80FF.
  - each with resp_valid at cycle 2.
- Word store 0xCAFEF00D to 0x00: single WRITE cycle with mem_we=1 and mem_a=0; resp at cycle 2; no READ state visited.
- Errors, each with resp_err=1 at cycle 1, mem_we never asserted, memory unchanged:
  - lh 0x03.
  - sw 0x06.
  - size 11.
  - lw 0x100 (index 64).
  - lw 0xFC (index 63) succeeds.
- Reset: reset_n low during the WRITE of a byte store -> mem_we=0 that cycle, memory unchanged, state IDLE and req_ready=1 next cycle.
- Handshake: req_valid held high across a load -> second request accepted only in the IDLE cycle after RESP; exactly one resp_valid pulse per request.
